// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with parity and framing status
module uart_rx #(
    parameter int   DATA_WIDTH  = 8,
    parameter logic PARITY_EN   = 1'b1,
    parameter logic PARITY_TYPE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_en_16x,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  frame_done;
    logic                  rx_m;
    logic                  rx_s;
    logic                  armed;
    logic [3:0]            s_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [1:0]            samp;
    logic                  maj;
    logic                  at_mid;
    logic                  at_end;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_bit;
    logic                  par_exp;

    // Majority vote of the captures at s_cnt 7 and 8 plus the live sample at 9
    assign maj      = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign at_mid   = baud_en_16x && (s_cnt == 4'd9);
    assign at_end   = baud_en_16x && (s_cnt == 4'd15);
    assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign par_exp  = (^shift_reg) ^ PARITY_TYPE;
    assign rx_busy  = (state != IDLE);

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the frame ends at mid-stop so the next start edge is not missed
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (baud_en_16x && !rx_s && armed) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (at_mid && maj) begin
                    state_nxt = IDLE;
                end else if (at_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (at_end && last_bit) begin
                    state_nxt = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (at_mid) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sample counter, captures, bit counter and data/parity shift storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt     <= '0;
            samp      <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else if (baud_en_16x) begin
            s_cnt <= (state == IDLE) ? 4'd0 : s_cnt + 4'd1;
            if (s_cnt == 4'd7) begin
                samp[0] <= rx_s;
            end
            if (s_cnt == 4'd8) begin
                samp[1] <= rx_s;
            end
            if (state == START && s_cnt == 4'd15) begin
                bit_cnt <= '0;
            end
            if (state == DATA && s_cnt == 4'd15 && !last_bit) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == DATA && s_cnt == 4'd9) begin
                shift_reg[bit_cnt] <= maj;
            end
            if (state == PARITY && s_cnt == 4'd9) begin
                par_bit <= maj;
            end
        end
    end

    // Start qualifier: after a frame the line must be seen high before a new start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (rx_s) begin
            armed <= 1'b1;
        end else if (frame_done) begin
            armed <= 1'b0;
        end
    end

    // Frame result registers, updated only when a frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= frame_done;
            if (frame_done) begin
                rx_data    <= shift_reg;
                parity_err <= PARITY_EN & (par_bit != par_exp);
                frame_err  <= ~maj;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed bench for uart_rx against a frame-level model
module tb_uart_rx;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_en_16x = 1'b0;
    logic [2:0] rx = 3'b111;
    logic [7:0] rdata [3];
    logic [2:0] rvalid;
    logic [2:0] perr;
    logic [2:0] ferr;
    logic [2:0] busy;

    int   tick_div = 16;
    int   bcnt = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   lat = 0;
    bit   lat_seen = 1'b0;
    bit   busy_seen = 1'b0;
    logic [2:0] vprev = 3'b000;
    int   checks = 0;
    int   failures = 0;

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bcnt >= tick_div - 1) begin
            bcnt        <= 0;
            baud_en_16x <= 1'b1;
        end else begin
            bcnt        <= bcnt + 1;
            baud_en_16x <= 1'b0;
        end
    end

    uart_rx u0 (
        .clk(clk), .rst_n(rst_n), .baud_en_16x(baud_en_16x), .rx(rx[0]),
        .rx_data(rdata[0]), .rx_valid(rvalid[0]), .parity_err(perr[0]),
        .frame_err(ferr[0]), .rx_busy(busy[0])
    );

    uart_rx #(.PARITY_EN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .baud_en_16x(baud_en_16x), .rx(rx[1]),
        .rx_data(rdata[1]), .rx_valid(rvalid[1]), .parity_err(perr[1]),
        .frame_err(ferr[1]), .rx_busy(busy[1])
    );

    uart_rx #(.PARITY_TYPE(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .baud_en_16x(baud_en_16x), .rx(rx[2]),
        .rx_data(rdata[2]), .rx_valid(rvalid[2]), .parity_err(perr[2]),
        .frame_err(ferr[2]), .rx_busy(busy[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic on_valid(input int k);
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        check($sformatf("valid_expected_%0d", k), 32'(n != 0), 32'd1);
        if (n == 0) return;
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        check($sformatf("rx_data_%0d", k), 32'(rdata[k]), 32'(e.d));
        check($sformatf("parity_err_%0d", k), 32'(perr[k]), 32'(e.pe));
        check($sformatf("frame_err_%0d", k), 32'(ferr[k]), 32'(e.fe));
        check($sformatf("busy_at_valid_%0d", k), 32'(busy[k]), 32'd0);
    endtask

    always begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    always begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (vprev[k]) check($sformatf("valid_1clk_%0d", k), 32'(rvalid[k]), 32'd0);
            if (rvalid[k]) begin
                on_valid(k);
                if (k == 0 && !lat_seen) begin
                    lat      = cyc - start_cyc;
                    lat_seen = 1'b1;
                end
            end
        end
        if (busy[0]) busy_seen = 1'b1;
        vprev = rvalid;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int bit_clks();
        return 16 * tick_div;
    endfunction

    // Drives one frame on all three lines; each line carries the framing its DUT expects
    task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [10:0] b0;
        logic [10:0] b1;
        logic [10:0] b2;
        logic        st;
        exp_t        e;
        st = ~bad_stop;
        b0 = {st, (^d) ^ bad_par, d, 1'b0};
        b1 = {1'b1, st, d, 1'b0};
        b2 = {st, (~^d) ^ bad_par, d, 1'b0};
        e.d  = d;
        e.pe = bad_par;
        e.fe = bad_stop;
        q0.push_back(e);
        q2.push_back(e);
        e.pe = 1'b0;
        q1.push_back(e);
        start_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            rx = {b2[i], b1[i], b0[i]};
            wait_clks(bit_clks());
        end
        rx = 3'b111;
    endtask

    task automatic drain(input string tag);
        wait_clks(bit_clks());
        check({tag, "_pending"}, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_data_%0d", tag, k), 32'(rdata[k]), 32'd0);
            check($sformatf("%s_valid_%0d", tag, k), 32'(rvalid[k]), 32'd0);
            check($sformatf("%s_perr_%0d", tag, k), 32'(perr[k]), 32'd0);
            check($sformatf("%s_ferr_%0d", tag, k), 32'(ferr[k]), 32'd0);
            check($sformatf("%s_busy_%0d", tag, k), 32'(busy[k]), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        bit         bp;
        bit         bs;

        rst_n = 1'b0;
        rx    = 3'b111;
        wait_clks(5);
        check_reset_state("reset");
        rst_n = 1'b1;
        wait_clks(2 * bit_clks());

        lat_seen = 1'b0;
        send(8'hA5, 1'b0, 1'b0);
        drain("a5");
        check("a5_latency_in_window", 32'(lat_seen && lat >= 2680 && lat <= 2760), 32'd1);

        send(8'h3C, 1'b1, 1'b0);
        drain("bad_parity");
        check("bad_parity_held", 32'(perr[0]), 32'd1);
        send(8'h3C, 1'b0, 1'b0);
        drain("good_parity");

        send(8'h55, 1'b0, 1'b1);
        wait_clks(2 * bit_clks());
        check("bad_stop_held", 32'(ferr[0]), 32'd1);
        send(8'h01, 1'b0, 1'b0);
        drain("after_break");

        busy_seen = 1'b0;
        rx = 3'b000;
        wait_clks(4 * tick_div);
        rx = 3'b111;
        wait_clks(2 * bit_clks());
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_clear", 32'(busy[0]), 32'd0);
        check("glitch_data_hold", 32'(rdata[0]), 32'h01);
        drain("glitch");

        send(8'h00, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        send(8'h81, 1'b0, 1'b0);
        drain("back_to_back");

        d  = 8'hF0;
        rx = 3'b000;
        wait_clks(bit_clks());
        for (int i = 0; i < 4; i++) begin
            rx = {3{d[i]}};
            wait_clks(bit_clks());
        end
        rx = {3{d[4]}};
        wait_clks(bit_clks() / 2);
        rst_n = 1'b0;
        wait_clks(2);
        check_reset_state("mid_reset");
        rx = 3'b111;
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(2 * bit_clks());
        check("mid_reset_idle", 32'(busy[0]), 32'd0);
        send(8'h0F, 1'b0, 1'b0);
        drain("after_reset");

        tick_div = 4;
        wait_clks(2 * bit_clks());
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 4) == 0);
            send(d, bp, bs);
            if (bs) wait_clks(2 * bit_clks() + int'($urandom_range(0, 20)));
            else    wait_clks(int'($urandom_range(0, 40)));
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
